lane_mem_sequencer: RTL and testbench
=====================================

LANE_MEM_SEQUENCER -- requirements
Module: lane_mem_sequencer

Interface
REQ-001 SHALL have parameter N_LANES, default 4, number of core lanes (1..32).
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mread  input  1  read request strobe, sampled in IDLE.
REQ-007 SHALL have port mwrite  input  1  write request strobe, sampled in IDLE.
REQ-008 SHALL have port mready  output  1  high when idle or transaction complete.
REQ-009 SHALL have port en  input  N_LANES  per-lane enable mask.
REQ-010 SHALL have port addr  input  N_LANES x AW  per-lane address.
REQ-011 SHALL have port wdata  input  N_LANES x DW  per-lane write data.
REQ-012 SHALL have port rdata  output  N_LANES x DW  per-lane read result, registered.
REQ-013 SHALL have port mem_addr  output  AW  address to single-port data memory.
REQ-014 SHALL have port mem_wdata  output  DW  write data to memory.
REQ-015 SHALL have port mem_rdata  input  DW  memory read data, valid in same clk cycle as mem_addr (memory clocked on inverted clk).
REQ-016 SHALL have port mem_wren  output  1  memory write enable.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE.
REQ-018 In IDLE with mwrite=1 SHALL latch en, addr, wdata, op=WRITE and go to BUSY; mwrite has priority when mread and mwrite both high.
REQ-019 In IDLE with mread=1 (mwrite=0) SHALL latch en, addr, op=READ and go to BUSY.
REQ-020 SHALL drive mready=0 in BUSY, 1 in IDLE and DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-021 In BUSY SHALL serve the lowest-index pending lane each cycle: mem_addr=latched addr, mem_wren=1 for WRITE, and clear that lane's pending bit.
REQ-022 For READ SHALL register mem_rdata into rdata[lane] at the end of the serving cycle.
REQ-023 SHALL go to DONE in the cycle after the pending mask becomes zero; empty mask at request goes straight to DONE (one cycle, no memory access).
REQ-024 Latency request-to-mready SHALL be k+1 cycles for k accesses issued.
REQ-025 Lanes not enabled SHALL retain previous rdata; rdata SHALL hold until overwritten by a later read.
REQ-026 mread/mwrite and changes to en/addr/wdata while BUSY/DONE SHALL be ignored.
REQ-027 Outside BUSY SHALL drive mem_wren=0 and hold mem_addr at its last value.
REQ-028 Same-address writes from several lanes SHALL leave the highest-index lane's data in memory.

Reset
REQ-029 reset SHALL force IDLE, mready=1, mem_wren=0, mem_addr=0, mem_wdata=0, all rdata=0, pending mask=0, on the next rising edge, including mid-transaction (in-flight access abandoned).

Configuration
REQ-030 With COALESCE_EN defined, a READ cycle SHALL also deliver mem_rdata to every pending lane whose address equals the served address and clear their bits.
REQ-031 With COALESCE_EN defined, a WRITE cycle SHALL write the highest-index pending lane of that address once and clear all matching bits.
REQ-032 Without COALESCE_EN, SHALL issue exactly one access per enabled lane; memory end-state SHALL be identical to the coalesced case.

Structure
REQ-033 SHALL place state enum, op enum and default AW/DW/N_LANES constants in shared package mem_ctrl_pkg.
REQ-034 SHALL use one sub-module lane_prio_enc (N_LANES mask -> lowest set index + valid).

Verification
REQ-035 Read en=0010, addr1=11, mem[11]=20 -> one access at 11, rdata[1]=20, mready high 2 cycles after request, other rdata unchanged.
REQ-036 Write en=1111, addr=20..23, wdata=9,20,55,24 -> wren in 4 consecutive cycles, addrs 20,21,22,23 ascending, mem matches, latency 5.
REQ-037 Request with en=0000 -> no mem_wren, mready low 0 cycles, DONE after 1 cycle.
REQ-038 Read en=1111 all addr=30, mem[30]=7 -> all rdata=7; 4 accesses without COALESCE_EN, 1 with it.
REQ-039 Write en=0110 same addr 40, wdata 5/6 -> mem[40]=6 both builds.
REQ-040 reset asserted in 2nd BUSY cycle of 4-lane read -> next cycle IDLE, mready=1, all rdata=0, no further accesses.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the lane memory sequencer.
package mem_ctrl_pkg;

    localparam int DEF_N_LANES = 4;
    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Priority encoder: index of the lowest set bit of mask, plus a valid flag.
module lane_prio_enc #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_mem_sequencer.sv
// Serialises per-lane read/write requests onto one single-port data memory.
// Optional build macro COALESCE_EN merges pending lanes that share the served address.
//
// state | meaning
// IDLE  | ready; sample mread/mwrite and latch the lane request
// BUSY  | one memory access per cycle for the lowest pending lane
// DONE  | transaction complete for one cycle, then back to IDLE
module lane_mem_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mread,
    input  logic                        mwrite,
    output logic                        mready,
    input  logic [N_LANES-1:0]          en,
    input  logic [N_LANES-1:0][AW-1:0]  addr,
    input  logic [N_LANES-1:0][DW-1:0]  wdata,
    output logic [N_LANES-1:0][DW-1:0]  rdata,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic [DW-1:0]               mem_rdata,
    output logic                        mem_wren
);

    localparam int IW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    state_t                       state_q, state_d;
    op_t                          op_q;
    logic [N_LANES-1:0]           pend_q;
    logic [N_LANES-1:0][AW-1:0]   addr_q;
    logic [N_LANES-1:0][DW-1:0]   wdata_q;
    logic [AW-1:0]                addr_hold_q;
    logic [DW-1:0]                wdata_hold_q;

    logic [IW-1:0]                sel;
    logic                         sel_vld;
    logic [IW-1:0]                wr_lane;
    logic [N_LANES-1:0]           serve_mask;
    logic                         start;

    lane_prio_enc #(.N(N_LANES)) u_prio_enc (
        .mask  (pend_q),
        .idx   (sel),
        .valid (sel_vld)
    );

    always_comb begin
        state_d    = state_q;
        serve_mask = '0;
        wr_lane    = sel;
        start      = 1'b0;
        mem_addr   = addr_hold_q;
        mem_wdata  = wdata_hold_q;
        mem_wren   = 1'b0;
        mready     = (state_q != BUSY);
        case (state_q)
            IDLE: begin
                if (mwrite || mread) begin
                    start   = 1'b1;
                    state_d = (en == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (sel_vld) begin
                    serve_mask[sel] = 1'b1;
`ifdef COALESCE_EN
                    // Ascending scan leaves wr_lane at the highest matching lane.
                    for (int i = 0; i < N_LANES; i++) begin
                        if (pend_q[i] && (addr_q[i] == addr_q[sel])) begin
                            serve_mask[i] = 1'b1;
                            wr_lane       = IW'(i);
                        end
                    end
`endif
                    mem_addr = addr_q[sel];
                    if (op_q == OP_WRITE) begin
                        mem_wren  = 1'b1;
                        mem_wdata = wdata_q[wr_lane];
                    end
                    if ((pend_q & ~serve_mask) == '0) begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            pend_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            rdata        <= '0;
        end else begin
            state_q      <= state_d;
            addr_hold_q  <= mem_addr;
            wdata_hold_q <= mem_wdata;
            if (start) begin
                pend_q <= en;
                addr_q <= addr;
                op_q   <= mwrite ? OP_WRITE : OP_READ;
                if (mwrite) begin
                    wdata_q <= wdata;
                end
            end
            if (state_q == BUSY) begin
                pend_q <= pend_q & ~serve_mask;
                if (op_q == OP_READ) begin
                    for (int i = 0; i < N_LANES; i++) begin
                        if (serve_mask[i]) begin
                            rdata[i] <= mem_rdata;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_mem_sequencer.sv
// Directed bench for lane_mem_sequencer; expectations follow COALESCE_EN when defined.
module tb_lane_mem_sequencer;

    logic                clk = 1'b0;
    logic                reset;
    logic                mread, mwrite, mready;
    logic [3:0]          en;
    logic [3:0][15:0]    addr, wdata, rdata;
    logic [15:0]         mem_addr, mem_wdata, mem_rdata;
    logic                mem_wren;

    logic [15:0]         mem [0:255];
    logic                bd_we = 1'b0;
    logic [7:0]          bd_addr = '0;
    logic [15:0]         bd_data = '0;

    int                  acc_cnt = 0;
    int                  wr_cnt  = 0;
    logic [15:0]         acc_addr [0:63];

    int                  n_tests = 0;
    int                  n_fail  = 0;

    lane_mem_sequencer #(.N_LANES(4), .AW(16), .DW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mread     (mread),
        .mwrite    (mwrite),
        .mready    (mready),
        .en        (en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_wren  (mem_wren)
    );

    always #5 clk = ~clk;

    // Data memory clocked on the falling edge; bd_* is a bench-side preload port.
    always @(negedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    always @(negedge clk) begin
        if (!reset && mready === 1'b0) begin
            acc_addr[acc_cnt[5:0]] <= mem_addr;
            acc_cnt <= acc_cnt + 1;
            if (mem_wren) wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mem_poke(input logic [7:0] a, input logic [15:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    // Returns to IDLE, issues one request, then scrambles inputs while waiting for mready.
    task automatic run_req(input logic wr, input logic rd, input logic [3:0] e,
                           input logic [3:0][15:0] a, input logic [3:0][15:0] d,
                           output int lat, output int acc0, output int wr0);
        step();
        acc0   = acc_cnt;
        wr0    = wr_cnt;
        mwrite = wr;
        mread  = rd;
        en     = e;
        addr   = a;
        wdata  = d;
        step();
        lat    = 1;
        mwrite = 1'b0;
        mread  = 1'b0;
        en     = 4'b1111;
        addr   = {4{16'h00FF}};
        wdata  = {4{16'hDEAD}};
        while (mready !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, a0, w0;
        reset  = 1'b1;
        mread  = 1'b0;
        mwrite = 1'b0;
        en     = '0;
        addr   = '0;
        wdata  = '0;
        step();
        step();
        chk("rst_mready", 32'(mready), 32'd1);
        chk("rst_wren",   32'(mem_wren), 32'd0);
        chk("rst_addr",   32'(mem_addr), 32'd0);
        chk("rst_wdata",  32'(mem_wdata), 32'd0);
        chk("rst_rdata",  32'(rdata), 32'd0);
        reset = 1'b0;

        // Four-lane write to distinct ascending addresses.
        run_req(1'b1, 1'b0, 4'b1111, {16'd23, 16'd22, 16'd21, 16'd20},
                {16'd24, 16'd55, 16'd20, 16'd9}, lat, a0, w0);
        chk("wr4_lat",   32'(lat), 32'd5);
        chk("wr4_wrcnt", 32'(wr_cnt - w0), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wr4_addr%0d", i), 32'(acc_addr[(a0 + i) % 64]), 32'(20 + i));
        chk("wr4_mem20", 32'(mem[20]), 32'd9);
        chk("wr4_mem21", 32'(mem[21]), 32'd20);
        chk("wr4_mem22", 32'(mem[22]), 32'd55);
        chk("wr4_mem23", 32'(mem[23]), 32'd24);
        chk("wr4_hold_addr", 32'(mem_addr), 32'd23);
        chk("wr4_done_wren", 32'(mem_wren), 32'd0);

        // Four lanes reading the same address.
        mem_poke(8'd30, 16'd7);
        run_req(1'b0, 1'b1, 4'b1111, {4{16'd30}}, '0, lat, a0, w0);
`ifdef COALESCE_EN
        chk("rd_same_lat", 32'(lat), 32'd2);
        chk("rd_same_acc", 32'(acc_cnt - a0), 32'd1);
`else
        chk("rd_same_lat", 32'(lat), 32'd5);
        chk("rd_same_acc", 32'(acc_cnt - a0), 32'd4);
`endif
        chk("rd_same_wr", 32'(wr_cnt - w0), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rd_same_rdata%0d", i), 32'(rdata[i]), 32'd7);

        // Single-lane read; other lanes keep their previous result.
        mem_poke(8'd11, 16'd20);
        run_req(1'b0, 1'b1, 4'b0010, {16'd30, 16'd30, 16'd11, 16'd30}, '0, lat, a0, w0);
        chk("rd1_lat",  32'(lat), 32'd2);
        chk("rd1_acc",  32'(acc_cnt - a0), 32'd1);
        chk("rd1_addr", 32'(acc_addr[a0 % 64]), 32'd11);
        chk("rd1_rdata1", 32'(rdata[1]), 32'd20);
        chk("rd1_rdata0", 32'(rdata[0]), 32'd7);
        chk("rd1_rdata2", 32'(rdata[2]), 32'd7);
        chk("rd1_rdata3", 32'(rdata[3]), 32'd7);

        // Empty mask goes straight to DONE.
        run_req(1'b1, 1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, {4{16'd99}}, lat, a0, w0);
        chk("empty_lat", 32'(lat), 32'd1);
        chk("empty_acc", 32'(acc_cnt - a0), 32'd0);
        chk("empty_wr",  32'(wr_cnt - w0), 32'd0);
        chk("empty_mem23", 32'(mem[23]), 32'd24);

        // Same-address write from lanes 1 and 2, mread also high (write wins).
        run_req(1'b1, 1'b1, 4'b0110, {4{16'd40}}, {16'd99, 16'd6, 16'd5, 16'd98}, lat, a0, w0);
`ifdef COALESCE_EN
        chk("wr_same_lat", 32'(lat), 32'd2);
        chk("wr_same_wr",  32'(wr_cnt - w0), 32'd1);
`else
        chk("wr_same_lat", 32'(lat), 32'd3);
        chk("wr_same_wr",  32'(wr_cnt - w0), 32'd2);
`endif
        chk("wr_same_mem40", 32'(mem[40]), 32'd6);
        chk("wr_same_rdata1", 32'(rdata[1]), 32'd20);

        // Reset during the second BUSY cycle of a four-lane read.
        mem_poke(8'd50, 16'h050A);
        mem_poke(8'd51, 16'h051B);
        mem_poke(8'd52, 16'h052C);
        mem_poke(8'd53, 16'h053D);
        step();
        mread = 1'b1;
        en    = 4'b1111;
        addr  = {16'd53, 16'd52, 16'd51, 16'd50};
        step();
        mread = 1'b0;
        step();
        chk("rst_mid_rdata0", 32'(rdata[0]), 32'h050A);
        chk("rst_mid_busy", 32'(mready), 32'd0);
        reset = 1'b1;
        step();
        chk("rst_mid_mready", 32'(mready), 32'd1);
        chk("rst_mid_rdata", 32'(rdata), 32'd0);
        chk("rst_mid_wren", 32'(mem_wren), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        a0 = acc_cnt;
        step();
        step();
        step();
        chk("rst_mid_noacc", 32'(acc_cnt - a0), 32'd0);
        chk("rst_mid_idle", 32'(mready), 32'd1);
        chk("rst_mid_rdata_hold", 32'(rdata), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
